// File: rtl/cvxif_copro_mux.sv
// cvxif_copro_mux: fans one core's CV-X-IF issue/commit/result channels out to NrCopro coprocessors.
// An ID ownership table steers each commit to its owner and screens returning results for orphans.
module cvxif_copro_mux #(
    parameter int NrCopro     = 2,
    parameter int XLEN        = 64,
    parameter int IdWidth     = 3,
    parameter int NrRgprPorts = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          issue_valid_i,
    output logic                          issue_ready_o,
    input  logic [31:0]                   issue_instr_i,
    input  logic [IdWidth-1:0]            issue_id_i,
    input  logic [NrRgprPorts*XLEN-1:0]   issue_rs_i,
    output logic                          issue_accept_o,
    output logic                          issue_we_o,
    input  logic                          commit_valid_i,
    input  logic [IdWidth-1:0]            commit_id_i,
    input  logic                          commit_kill_i,
    output logic                          result_valid_o,
    input  logic                          result_ready_i,
    output logic [IdWidth-1:0]            result_id_o,
    output logic [XLEN-1:0]               result_data_o,
    output logic [4:0]                    result_rd_o,
    output logic [NrCopro-1:0]            cp_issue_valid_o,
    input  logic [NrCopro-1:0]            cp_issue_ready_i,
    input  logic [NrCopro-1:0]            cp_issue_accept_i,
    input  logic [NrCopro-1:0]            cp_issue_we_i,
    output logic [31:0]                   cp_issue_instr_o,
    output logic [IdWidth-1:0]            cp_issue_id_o,
    output logic [NrRgprPorts*XLEN-1:0]   cp_issue_rs_o,
    output logic [NrCopro-1:0]            cp_commit_valid_o,
    output logic [NrCopro-1:0]            cp_commit_kill_o,
    output logic [IdWidth-1:0]            cp_commit_id_o,
    input  logic [NrCopro-1:0]            cp_result_valid_i,
    output logic [NrCopro-1:0]            cp_result_ready_o,
    input  logic [NrCopro*IdWidth-1:0]    cp_result_id_i,
    input  logic [NrCopro*XLEN-1:0]       cp_result_data_i,
    input  logic [NrCopro*5-1:0]          cp_result_rd_i,
    output logic                          err_multi_accept_o,
    output logic                          err_orphan_result_o
);
    localparam int NrId = 2 ** IdWidth;
    localparam int OW   = NrCopro > 1 ? $clog2(NrCopro) : 1;

    logic [NrId-1:0]    r_valid;
    logic [NrId-1:0]    r_we;
    logic [OW-1:0]      r_owner [NrId];
    logic [OW-1:0]      r_ptr;
    logic               r_res_valid;
    logic [IdWidth-1:0] r_res_id;
    logic [XLEN-1:0]    r_res_data;
    logic [4:0]         r_res_rd;
    logic               r_err_multi;
    logic               r_err_orphan;

    logic               w_stall;
    logic               w_issue_hs;
    logic [OW-1:0]      w_sel;
    logic [OW-1:0]      w_gnt;
    logic [OW-1:0]      w_cand;
    logic               w_gnt_any;
    logic               w_space;
    logic               w_res_hs;
    logic               w_orphan;
    logic               w_commit_hit;
    logic               w_commit_clr;
    logic [IdWidth-1:0] w_res_id;
    logic [XLEN-1:0]    w_res_data;
    logic [4:0]         w_res_rd;

    // An ID still in flight must not be reissued: stall the whole issue channel.
    assign w_stall          = r_valid[issue_id_i];
    assign issue_ready_o    = !w_stall && &cp_issue_ready_i;
    assign cp_issue_valid_o = {NrCopro{issue_valid_i && !w_stall}};
    assign w_issue_hs       = issue_valid_i && issue_ready_o;
    assign issue_accept_o   = |cp_issue_accept_i;
    assign issue_we_o       = cp_issue_we_i[w_sel];
    assign cp_issue_instr_o = issue_instr_i;
    assign cp_issue_id_o    = issue_id_i;
    assign cp_issue_rs_o    = issue_rs_i;

    always_comb begin
        w_sel = '0;
        for (int i = NrCopro - 1; i >= 0; i--)
            if (cp_issue_accept_i[i]) w_sel = OW'(i);
    end

    assign w_commit_hit     = commit_valid_i && r_valid[commit_id_i];
    assign w_commit_clr     = w_commit_hit && (commit_kill_i || !r_we[commit_id_i]);
    assign cp_commit_kill_o = {NrCopro{commit_kill_i}};
    assign cp_commit_id_o   = commit_id_i;

    always_comb begin
        cp_commit_valid_o = '0;
        for (int i = 0; i < NrCopro; i++)
            cp_commit_valid_o[i] = w_commit_hit && r_owner[commit_id_i] == OW'(i);
    end

    // r_ptr is the highest-priority requester; scanning downward leaves the first hit from r_ptr.
    always_comb begin
        w_gnt     = '0;
        w_gnt_any = 1'b0;
        w_cand    = '0;
        for (int k = NrCopro - 1; k >= 0; k--) begin
            w_cand = (int'(r_ptr) + k >= NrCopro) ? OW'(int'(r_ptr) + k - NrCopro) : OW'(int'(r_ptr) + k);
            if (cp_result_valid_i[w_cand]) begin
                w_gnt     = w_cand;
                w_gnt_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_res_id          = '0;
        w_res_data        = '0;
        w_res_rd          = '0;
        cp_result_ready_o = '0;
        for (int i = 0; i < NrCopro; i++)
            if (OW'(i) == w_gnt) begin
                w_res_id             = cp_result_id_i[i*IdWidth +: IdWidth];
                w_res_data           = cp_result_data_i[i*XLEN +: XLEN];
                w_res_rd             = cp_result_rd_i[i*5 +: 5];
                cp_result_ready_o[i] = w_res_hs;
            end
    end

    assign w_space  = !r_res_valid || result_ready_i;
    assign w_res_hs = w_gnt_any && w_space;
    assign w_orphan = !r_valid[w_res_id] || r_owner[w_res_id] != w_gnt;

    // Clears only hit valid entries and sets only free ones, so same-ID set/clear never collide.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid      <= '0;
            r_we         <= '0;
            r_owner      <= '{default: '0};
            r_ptr        <= '0;
            r_res_valid  <= 1'b0;
            r_res_id     <= '0;
            r_res_data   <= '0;
            r_res_rd     <= '0;
            r_err_multi  <= 1'b0;
            r_err_orphan <= 1'b0;
        end else begin
            r_err_multi  <= w_issue_hs && $countones(cp_issue_accept_i) > 1;
            r_err_orphan <= w_res_hs && w_orphan;
            if (w_res_hs) r_ptr <= (w_gnt == OW'(NrCopro - 1)) ? '0 : w_gnt + OW'(1);
            if (w_commit_clr) r_valid[commit_id_i] <= 1'b0;
            if (w_res_hs && !w_orphan) begin
                r_valid[w_res_id] <= 1'b0;
                r_res_valid       <= 1'b1;
                r_res_id          <= w_res_id;
                r_res_data        <= w_res_data;
                r_res_rd          <= w_res_rd;
            end else if (result_ready_i) begin
                r_res_valid <= 1'b0;
            end
            if (w_issue_hs && issue_accept_o) begin
                r_valid[issue_id_i] <= 1'b1;
                r_owner[issue_id_i] <= w_sel;
                r_we[issue_id_i]    <= cp_issue_we_i[w_sel];
            end
        end
    end

    assign result_valid_o      = r_res_valid;
    assign result_id_o         = r_res_id;
    assign result_data_o       = r_res_data;
    assign result_rd_o         = r_res_rd;
    assign err_multi_accept_o  = r_err_multi;
    assign err_orphan_result_o = r_err_orphan;
endmodule

// File: tb/tb_cvxif_copro_mux.sv
// tb_cvxif_copro_mux: directed CV-X-IF scenarios followed by randomized traffic,
// every cycle compared against an ID-ownership reference model.
module tb_cvxif_copro_mux;
    localparam int NC = 2, XL = 64, IW = 3, NR = 2, NID = 8;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            issue_valid, issue_ready_o, issue_accept_o, issue_we_o;
    logic [31:0]     issue_instr;
    logic [IW-1:0]   issue_id, commit_id, result_id_o, cp_issue_id_o, cp_commit_id_o;
    logic [NR*XL-1:0] issue_rs, cp_issue_rs_o;
    logic            commit_valid, commit_kill, result_valid_o, result_ready;
    logic [XL-1:0]   result_data_o;
    logic [4:0]      result_rd_o;
    logic [NC-1:0]   cp_issue_valid_o, cp_issue_ready, cp_issue_accept, cp_issue_we;
    logic [31:0]     cp_issue_instr_o;
    logic [NC-1:0]   cp_commit_valid_o, cp_commit_kill_o, cp_result_valid, cp_result_ready_o;
    logic [NC*IW-1:0] cp_result_id;
    logic [NC*XL-1:0] cp_result_data;
    logic [NC*5-1:0] cp_result_rd;
    logic            err_multi_accept_o, err_orphan_result_o;

    always #5 clk = ~clk;

    cvxif_copro_mux #(.NrCopro(NC), .XLEN(XL), .IdWidth(IW), .NrRgprPorts(NR)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready_o), .issue_instr_i(issue_instr),
        .issue_id_i(issue_id), .issue_rs_i(issue_rs), .issue_accept_o(issue_accept_o), .issue_we_o(issue_we_o),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready), .result_id_o(result_id_o),
        .result_data_o(result_data_o), .result_rd_o(result_rd_o),
        .cp_issue_valid_o(cp_issue_valid_o), .cp_issue_ready_i(cp_issue_ready),
        .cp_issue_accept_i(cp_issue_accept), .cp_issue_we_i(cp_issue_we),
        .cp_issue_instr_o(cp_issue_instr_o), .cp_issue_id_o(cp_issue_id_o), .cp_issue_rs_o(cp_issue_rs_o),
        .cp_commit_valid_o(cp_commit_valid_o), .cp_commit_kill_o(cp_commit_kill_o), .cp_commit_id_o(cp_commit_id_o),
        .cp_result_valid_i(cp_result_valid), .cp_result_ready_o(cp_result_ready_o),
        .cp_result_id_i(cp_result_id), .cp_result_data_i(cp_result_data), .cp_result_rd_i(cp_result_rd),
        .err_multi_accept_o(err_multi_accept_o), .err_orphan_result_o(err_orphan_result_o)
    );

    int n_pass = 0, n_total = 0;

    // Reference model: who owns each ID, the pending output result, error pulses, last granted copro.
    bit            mv [NID];
    int            mo [NID];
    bit            mwe [NID];
    bit            m_rv;
    logic [IW-1:0] m_rid;
    logic [XL-1:0] m_rdata;
    logic [4:0]    m_rrd;
    bit            m_emul, m_eorph;
    int            m_last;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NID; i++) mv[i] = 0;
        m_rv = 0;
        m_emul = 0;
        m_eorph = 0;
        m_last = NC - 1;
    endtask

    task automatic idle();
        issue_valid = 0;
        cp_issue_accept = 0;
        cp_issue_we = 0;
        cp_issue_ready = 2'b11;
        commit_valid = 0;
        commit_kill = 0;
        cp_result_valid = 0;
        result_ready = 1;
    endtask

    function automatic logic [IW-1:0] pick_id(int g);
        int q[$];
        for (int i = 0; i < NID; i++) if (mv[i] && (g < 0 || mo[i] == g)) q.push_back(i);
        if (q.size() == 0 || $urandom_range(0, 3) == 0) return IW'($urandom);
        return IW'(q[$urandom_range(0, q.size() - 1)]);
    endfunction

    // Checks every output for the current inputs, then advances the model across one clock edge.
    task automatic cycle();
        bit stall, hs, any, space, rhs, orph, cclr, rr;
        int sel, g;
        logic [IW-1:0] iid, cid, rid;
        logic [XL-1:0] rdat;
        logic [4:0] rrd;
        logic [NC-1:0] acc, we;
        #2;
        stall = mv[issue_id];
        hs = issue_valid && !stall && (&cp_issue_ready);
        acc = cp_issue_accept;
        we = cp_issue_we;
        iid = issue_id;
        cid = commit_id;
        rr = result_ready;
        sel = -1;
        for (int k = NC - 1; k >= 0; k--) if (acc[k]) sel = k;
        chk("issue_valid_fanout", cp_issue_valid_o, (issue_valid && !stall) ? 2'b11 : 2'b00);
        chk("issue_ready", issue_ready_o, !stall && (&cp_issue_ready));
        chk("issue_accept", issue_accept_o, sel >= 0);
        if (sel >= 0) chk("issue_we", issue_we_o, we[sel]);
        chk("instr_fanout", cp_issue_instr_o, issue_instr);
        chk("id_fanout", cp_issue_id_o, issue_id);
        chk("rs_fanout", cp_issue_rs_o, issue_rs);
        chk("commit_route", cp_commit_valid_o, (commit_valid && mv[cid]) ? 2'b01 << mo[cid] : 2'b00);
        chk("commit_kill", cp_commit_kill_o, {2{commit_kill}});
        any = 0;
        g = 0;
        for (int k = 1; k <= NC; k++)
            if (!any && cp_result_valid[(m_last + k) % NC]) begin
                any = 1;
                g = (m_last + k) % NC;
            end
        space = !m_rv || rr;
        rhs = any && space;
        chk("result_grant", cp_result_ready_o, rhs ? 2'b01 << g : 2'b00);
        chk("result_valid", result_valid_o, m_rv);
        if (m_rv) begin
            chk("result_id", result_id_o, m_rid);
            chk("result_data", result_data_o, m_rdata);
            chk("result_rd", result_rd_o, m_rrd);
        end
        chk("err_multi", err_multi_accept_o, m_emul);
        chk("err_orphan", err_orphan_result_o, m_eorph);
        rid = cp_result_id[g*IW +: IW];
        rdat = cp_result_data[g*XL +: XL];
        rrd = cp_result_rd[g*5 +: 5];
        orph = !mv[rid] || mo[rid] != g;
        cclr = commit_valid && mv[cid] && (commit_kill || !mwe[cid]);
        @(posedge clk);
        #1;
        m_emul = hs && $countones(acc) > 1;
        m_eorph = rhs && orph;
        if (rr) m_rv = 0;
        if (rhs && !orph) begin
            m_rv = 1;
            m_rid = rid;
            m_rdata = rdat;
            m_rrd = rrd;
            mv[rid] = 0;
        end
        if (rhs) m_last = g;
        if (cclr) mv[cid] = 0;
        if (hs && sel >= 0) begin
            mv[iid] = 1;
            mo[iid] = sel;
            mwe[iid] = we[sel];
        end
    endtask

    initial begin
        idle();
        issue_instr = 0;
        issue_id = 0;
        issue_rs = 0;
        commit_id = 0;
        cp_result_id = 0;
        cp_result_data = 0;
        cp_result_rd = 0;
        rst_i = 1;
        model_reset();
        #3;
        chk("rst_result_valid", result_valid_o, 0);
        chk("rst_err_multi", err_multi_accept_o, 0);
        chk("rst_err_orphan", err_orphan_result_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 0;
        cycle();

        // Issue id 2 to cp1, commit it, return 0xDEAD.
        issue_valid = 1;
        issue_id = 2;
        issue_instr = 32'h0000_200b;
        issue_rs = {$urandom, $urandom, $urandom, $urandom};
        cp_issue_accept = 2'b10;
        cp_issue_we = 2'b10;
        #1;
        chk("s1_accept", issue_accept_o, 1);
        chk("s1_we", issue_we_o, 1);
        cycle();
        idle();
        commit_valid = 1;
        commit_id = 2;
        #1;
        chk("s1_commit_only_cp1", cp_commit_valid_o, 2'b10);
        cycle();
        idle();
        cp_result_valid = 2'b10;
        cp_result_id[5:3] = 3'd2;
        cp_result_data[127:64] = 64'hDEAD;
        cp_result_rd[9:5] = 5'd7;
        #1;
        chk("s1_result_grant", cp_result_ready_o, 2'b10);
        cycle();
        idle();
        chk("s1_result_next_cycle", result_valid_o, 1);
        chk("s1_result_data", result_data_o, 64'hDEAD);
        chk("s1_result_id", result_id_o, 2);
        chk("s1_id2_freed", issue_ready_o, 1);
        cycle();

        // ID reuse stall on id 3 until its result completes.
        issue_valid = 1;
        issue_id = 3;
        cp_issue_accept = 2'b01;
        cp_issue_we = 2'b01;
        cycle();
        cp_issue_accept = 2'b00;
        #1;
        chk("s2_stall_ready", issue_ready_o, 0);
        chk("s2_stall_fanout", cp_issue_valid_o, 0);
        cycle();
        cycle();
        cp_result_valid = 2'b01;
        cp_result_id[2:0] = 3'd3;
        cp_result_data[63:0] = {$urandom, $urandom};
        cp_result_rd[4:0] = 5'd3;
        #1;
        chk("s2_stall_during_result", issue_ready_o, 0);
        cycle();
        cp_result_valid = 0;
        #1;
        chk("s2_released", issue_ready_o, 1);
        cycle();
        idle();

        // Double accept: lowest index owns, one-cycle error pulse.
        issue_valid = 1;
        issue_id = 1;
        cp_issue_accept = 2'b11;
        cp_issue_we = 2'b01;
        cycle();
        idle();
        chk("s3_err_multi", err_multi_accept_o, 1);
        commit_valid = 1;
        commit_id = 1;
        #1;
        chk("s3_owner0", cp_commit_valid_o, 2'b01);
        cycle();
        idle();
        chk("s3_err_once", err_multi_accept_o, 0);
        cycle();

        // Round robin: ids 4,5 on cp0 and 6,7 on cp1; cp0 was granted last so cp1 leads.
        for (int i = 4; i < 8; i++) begin
            issue_valid = 1;
            issue_id = IW'(i);
            cp_issue_accept = (i < 6) ? 2'b01 : 2'b10;
            cp_issue_we = cp_issue_accept;
            cycle();
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            cp_result_valid = 2'b11;
            cp_result_id = {(k == 0) ? 3'd6 : 3'd7, (k <= 1) ? 3'd4 : 3'd5};
            cp_result_data = {$urandom, $urandom, $urandom, $urandom};
            cp_result_rd = 10'($urandom);
            #1;
            chk($sformatf("s4_grant%0d", k), cp_result_ready_o, (k % 2 == 0) ? 2'b10 : 2'b01);
            cycle();
            chk($sformatf("s4_throughput%0d", k), result_valid_o, 1);
        end
        idle();

        // Orphan result for unowned id 5 from cp1.
        cp_result_valid = 2'b10;
        cp_result_id[5:3] = 3'd5;
        #1;
        chk("s5_orphan_consumed", cp_result_ready_o, 2'b10);
        cycle();
        idle();
        chk("s5_orphan_pulse", err_orphan_result_o, 1);
        chk("s5_no_result", result_valid_o, 0);
        cycle();
        chk("s5_pulse_once", err_orphan_result_o, 0);

        // Kill frees id 4 (we=1); reissue accepted at once.
        issue_valid = 1;
        issue_id = 4;
        cp_issue_accept = 2'b01;
        cp_issue_we = 2'b01;
        cycle();
        idle();
        commit_valid = 1;
        commit_id = 4;
        commit_kill = 1;
        #1;
        chk("s6_kill_route", cp_commit_valid_o, 2'b01);
        chk("s6_kill_fanout", cp_commit_kill_o, 2'b11);
        cycle();
        idle();
        issue_valid = 1;
        issue_id = 4;
        cp_issue_accept = 2'b10;
        cp_issue_we = 2'b10;
        #1;
        chk("s6_reissue", issue_ready_o, 1);
        cycle();
        idle();

        // Asynchronous reset while a result is held.
        issue_valid = 1;
        issue_id = 0;
        cp_issue_accept = 2'b10;
        cp_issue_we = 2'b10;
        cycle();
        idle();
        result_ready = 0;
        cp_result_valid = 2'b10;
        cp_result_id[5:3] = 3'd0;
        cp_result_data[127:64] = 64'h1234_5678;
        cycle();
        cp_result_valid = 0;
        chk("s7_held", result_valid_o, 1);
        cycle();
        #2;
        rst_i = 1;
        #1;
        chk("s7_async_clear", result_valid_o, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_i = 0;
        idle();
        issue_id = 4;
        #1;
        chk("s7_table_empty", issue_ready_o, 1);
        cycle();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            issue_valid = 1'($urandom_range(0, 1));
            issue_id = IW'($urandom);
            issue_instr = $urandom;
            issue_rs = {$urandom, $urandom, $urandom, $urandom};
            cp_issue_ready = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom);
            cp_issue_accept = 2'($urandom);
            cp_issue_we = 2'($urandom);
            commit_valid = 1'($urandom_range(0, 1));
            commit_id = pick_id(-1);
            commit_kill = ($urandom_range(0, 3) == 0);
            result_ready = ($urandom_range(0, 3) != 0);
            for (int g = 0; g < NC; g++) begin
                cp_result_valid[g] = 1'($urandom_range(0, 1));
                cp_result_id[g*IW +: IW] = pick_id(g);
                cp_result_data[g*XL +: XL] = {$urandom, $urandom};
                cp_result_rd[g*5 +: 5] = 5'($urandom);
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
